// File: rtl/conv_2d_feeder_pkg.sv
// rtl/conv_2d_feeder_pkg.sv - shared constants and state type for the convolution feeder
package conv_pkg;

  localparam int N_DEF = 5;
  localparam int M_DEF = 3;
  localparam int DW    = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/conv_2d_feeder_if.sv
// rtl/conv_2d_feeder_if.sv - host write port and element stream of the convolution feeder
interface conv_2d_feeder_if #(
  parameter int AW = 5
) ();
  import conv_pkg::*;

  logic          wr_en;
  logic          wr_sel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          first;
  logic          last;

  // master: host + downstream sink side; slave: the feeder itself
  modport master (
    output wr_en, wr_sel, wr_addr, wr_data, out_ready,
    input  out_valid, a, b, first, last
  );

  modport slave (
    input  wr_en, wr_sel, wr_addr, wr_data, out_ready,
    output out_valid, a, b, first, last
  );

endinterface

// File: rtl/conv_2d_feeder_raster_cnt.sv
// rtl/conv_2d_feeder_raster_cnt.sv - row-major (i,j) counter over a DIMxDIM grid
module conv_raster_cnt #(
  parameter int DIM = 5,
  parameter int CW  = $clog2(DIM)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] i,
  output logic [CW-1:0] j,
  output logic          first,
  output logic          last,
  output logic          wrap
);

  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;

  assign i     = r_i;
  assign j     = r_j;
  assign first = (r_i == '0) && (r_j == '0);
  assign wrap  = (r_j == CW'(DIM - 1));
  assign last  = wrap && (r_i == CW'(DIM - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_i <= '0;
      r_j <= '0;
    end else if (advance) begin
      if (wrap) begin
        r_j <= '0;
        r_i <= last ? '0 : r_i + 1'b1;
      end else begin
        r_j <= r_j + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_2d_feeder.sv
// rtl/conv_2d_feeder.sv - buffers an NxN image and MxM kernel and streams them in raster order
module conv_2d_feeder
  import conv_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int M  = M_DEF,
  parameter int AW = $clog2(N * N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  conv_2d_feeder_if.slave     bus
);

  localparam int CW = $clog2(N);
  localparam int KW = (M > 1) ? $clog2(M * M) : 1;

  logic [DW-1:0] r_img [N*N];
  logic [DW-1:0] r_ker [M*M];

  feeder_state_t r_state;
  logic          r_busy;
  logic          r_done;
  logic          r_out_valid;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_b;

  logic [CW-1:0] w_i, w_j, w_ni, w_nj;
  logic          w_cnt_first, w_cnt_last, w_wrap;
  logic          w_hs, w_start, w_wr_img, w_wr_ker;
  logic [AW-1:0] w_img_idx;
  logic [KW-1:0] w_ker_idx;
  logic [DW-1:0] w_a_next, w_b_next, w_a0, w_b0;

  assign w_hs     = r_out_valid && bus.out_ready;
  assign w_start  = (r_state == IDLE) && start;
  assign w_wr_img = bus.wr_en && !bus.wr_sel && (r_state == IDLE) && (32'(bus.wr_addr) < N * N);
  assign w_wr_ker = bus.wr_en &&  bus.wr_sel && (r_state == IDLE) && (32'(bus.wr_addr) < M * M);

  conv_raster_cnt #(.DIM(N), .CW(CW)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_start),
    .advance (w_hs),
    .i       (w_i),
    .j       (w_j),
    .first   (w_cnt_first),
    .last    (w_cnt_last),
    .wrap    (w_wrap)
  );

  // Buffers carry no reset so a host load survives a reset of the stream logic.
  always_ff @(posedge clk) begin
    if (w_wr_img) r_img[bus.wr_addr] <= bus.wr_data;
    if (w_wr_ker) r_ker[bus.wr_addr[KW-1:0]] <= bus.wr_data;
  end

  assign w_ni      = w_wrap ? w_i + 1'b1 : w_i;
  assign w_nj      = w_wrap ? '0 : w_j + 1'b1;
  assign w_img_idx = AW'(w_ni) * AW'(N) + AW'(w_nj);
  assign w_ker_idx = KW'(w_ni) * KW'(M) + KW'(w_nj);
  assign w_a_next  = r_img[w_img_idx];
  assign w_b_next  = ((32'(w_ni) < M) && (32'(w_nj) < M)) ? r_ker[w_ker_idx] : '0;

  // Element (0,0) bypasses a same-cycle host write so the pass sees the new byte.
  assign w_a0 = (w_wr_img && bus.wr_addr == '0) ? bus.wr_data : r_img[0];
  assign w_b0 = (w_wr_ker && bus.wr_addr == '0) ? bus.wr_data : r_ker[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state     <= STREAM;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b1;
            r_a         <= w_a0;
            r_b         <= w_b0;
          end
        end
        STREAM: begin
          if (w_hs) begin
            if (w_cnt_last) begin
              r_state     <= DONE;
              r_busy      <= 1'b0;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_a         <= '0;
              r_b         <= '0;
            end else begin
              r_a <= w_a_next;
              r_b <= w_b_next;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign bus.out_valid = r_out_valid;
  assign bus.a         = r_a;
  assign bus.b         = r_b;
  assign bus.first     = r_out_valid && w_cnt_first;
  assign bus.last      = r_out_valid && w_cnt_last;

endmodule

// File: tb/tb_conv_2d_feeder.sv
// tb/tb_conv_2d_feeder.sv - scoreboard bench for conv_2d_feeder with N=5, M=3
module tb_conv_2d_feeder;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       first;
    logic       last;
  } elem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  conv_2d_feeder_if #(.AW(5)) bus ();

  conv_2d_feeder #(.N(5), .M(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  elem_t      exp_q[$];
  logic [7:0] m_img [25];
  logic [7:0] m_ker [9];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         hs_count = 0;
  int         done_seen = 0;
  int         ready_mode = 0;
  logic       pend_done = 1'b0;

  // sink ready: mode 0 always ready, mode 1 repeats 1,0,0,1
  initial begin
    logic [3:0] pat;
    int k;
    pat = 4'b1001;
    k = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (ready_mode == 0) ? 1'b1 : pat[k % 4];
      k++;
    end
  end

  // monitor: pops the scoreboard on every handshake, checks stalls and done
  initial begin
    elem_t cur, prev, e;
    logic  stall_prev;
    stall_prev = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = '{a: bus.a, b: bus.b, first: bus.first, last: bus.last};
      if (rst) begin
        stall_prev = 1'b0;
        pend_done  = 1'b0;
      end else begin
        if (pend_done) begin
          n_cmp++;
          if (!(done && !busy && !bus.out_valid)) begin
            n_fail++;
            $display("FAIL done_pulse: done=%0b busy=%0b valid=%0b, want 1 0 0", done, busy, bus.out_valid);
          end
          n_cmp++;
          if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL element_count: %0d expected elements left over, want 0", exp_q.size());
          end
          pend_done = 1'b0;
          done_seen++;
        end else if (done) begin
          n_cmp++;
          n_fail++;
          $display("FAIL spurious_done: done=1 with no final handshake, want 0");
        end
        if (stall_prev) begin
          n_cmp++;
          if (!bus.out_valid || cur != prev) begin
            n_fail++;
            $display("FAIL stall_hold: valid=%0b a=%h b=%h f=%0b l=%0b, want valid=1 a=%h b=%h f=%0b l=%0b",
                     bus.out_valid, cur.a, cur.b, cur.first, cur.last, prev.a, prev.b, prev.first, prev.last);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL extra_element: a=%h b=%h with empty scoreboard", cur.a, cur.b);
          end else begin
            e = exp_q.pop_front();
            if (cur != e) begin
              n_fail++;
              $display("FAIL element[%0d]: a=%h b=%h f=%0b l=%0b, want a=%h b=%h f=%0b l=%0b",
                       hs_count, cur.a, cur.b, cur.first, cur.last, e.a, e.b, e.first, e.last);
            end
            if (e.last) pend_done = 1'b1;
          end
          hs_count++;
        end
        stall_prev = bus.out_valid && !bus.out_ready;
        prev = cur;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic wr(input logic sel, input logic [4:0] addr, input logic [7:0] data);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_addr = addr; bus.wr_data = data;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic push_pass();
    elem_t e;
    for (int k = 0; k < 25; k++) begin
      e.a     = m_img[k];
      e.b     = ((k / 5) < 3 && (k % 5) < 3) ? m_ker[(k / 5) * 3 + (k % 5)] : 8'h00;
      e.first = (k == 0);
      e.last  = (k == 24);
      exp_q.push_back(e);
    end
  endtask

  // with_wr: drive an image write to addr 0 in the same cycle as start
  task automatic start_pass(input logic with_wr, input logic [7:0] wdata);
    push_pass();
    @(posedge clk);
    #1;
    start = 1'b1;
    if (with_wr) begin
      bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = wdata;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    check("start_latency_valid", {7'd0, bus.out_valid}, 8'd1);
    check("start_latency_busy", {7'd0, busy}, 8'd1);
  endtask

  task automatic wait_done();
    int base;
    bit ok;
    base = done_seen;
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      if (done_seen > base) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL pass_timeout: no done within 400 cycles, %0d elements outstanding", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit reached;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy",  {7'd0, busy}, 8'd0);
    check("reset_valid", {7'd0, bus.out_valid}, 8'd0);
    check("reset_a",     bus.a, 8'd0);
    check("reset_b",     bus.b, 8'd0);
    check("reset_flags", {5'd0, bus.first, bus.last, done}, 8'd0);

    for (int k = 0; k < 25; k++) begin
      wr(1'b0, 5'(k), 8'(k + 1));
      m_img[k] = 8'(k + 1);
    end
    for (int k = 0; k < 9; k++) begin
      wr(1'b1, 5'(k), 8'(k + 1));
      m_ker[k] = 8'(k + 1);
    end

    // full-rate pass
    start_pass(1'b0, 8'h00);
    wait_done();

    // stalled pass
    ready_mode = 1;
    start_pass(1'b0, 8'h00);
    wait_done();
    ready_mode = 0;

    // write and start during a pass are both ignored
    start_pass(1'b0, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 5'd0; bus.wr_data = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("no_restart_valid", {7'd0, bus.out_valid}, 8'd0);
    start_pass(1'b0, 8'h00);
    wait_done();

    // reset after the 10th handshake
    base = hs_count;
    start_pass(1'b0, 8'h00);
    reached = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      if (hs_count >= base + 10) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) begin
      n_cmp++;
      n_fail++;
      $display("FAIL reset_setup: only %0d handshakes seen, want 10", hs_count - base);
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midreset_valid", {7'd0, bus.out_valid}, 8'd0);
    check("midreset_busy",  {7'd0, busy}, 8'd0);
    repeat (30) @(posedge clk);
    start_pass(1'b0, 8'h00);
    wait_done();

    // out-of-range kernel write
    wr(1'b1, 5'd9, 8'hAA);
    start_pass(1'b0, 8'h00);
    wait_done();

    // write and start in the same idle cycle
    m_img[0] = 8'h55;
    start_pass(1'b1, 8'h55);
    wait_done();

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
